muskoka_mem_arbiter: RTL and testbench
======================================

Name: muskoka_mem_arbiter

Overview:
Shares the single Muskoka memory bus port between the instruction-fetch stage (F port) and the load/store path (D port).
- Grants one requester at a time. Data has priority; an anti-starvation counter periodically forces a fetch grant.
- Drives registered bus strobes, returns read data with a one-cycle ack or err pulse, and aborts stuck cycles with a timeout.
- Sits between cpu_fetch/the load-store unit and the memory/peripheral interconnect.

Parameters:
- DATA_BURST_MAX, 4: max consecutive D grants while F is waiting before F is forced; range 1..15.
- TIMEOUT, 255: cycles with mem_stb_o high and no ack before abort; 0 disables; range 0..1023.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- f_req_i  in  1  fetch request, held until f_ack_o/f_err_o
- f_adr_i  in  32  fetch address, word aligned
- f_dat_o  out  32  fetch read data, valid with f_ack_o
- f_ack_o  out  1  fetch complete, one-cycle pulse
- f_err_o  out  1  fetch timed out, one-cycle pulse
- d_req_i  in  1  data request, held until d_ack_o/d_err_o
- d_we_i  in  1  1 = write
- d_adr_i  in  32  data address
- d_dat_i  in  32  write data
- d_sel_i  in  4  byte lanes
- d_dat_o  out  32  read data, valid with d_ack_o
- d_ack_o  out  1  data complete, one-cycle pulse
- d_err_o  out  1  data timed out, one-cycle pulse
- mem_stb_o  out  1  bus strobe (also cycle-valid)
- mem_we_o  out  1  bus write enable
- mem_adr_o  out  32  bus address
- mem_dat_o  out  32  bus write data
- mem_sel_o  out  4  bus byte lanes
- mem_dat_i  in  32  bus read data
- mem_ack_i  in  1  bus acknowledge
- grant_o  out  2  current owner: 00 none, 01 F, 10 D

Behaviour:
Outputs:
- All outputs are registered.
- While rst_i is low, all outputs are 0 (including dat_o), state is IDLE, and the streak and timeout counters are 0.
- Reset asserted mid-transaction drops mem_stb_o immediately and generates no ack/err.

States: IDLE, BUS_F, BUS_D, DONE.

IDLE: reqs are sampled at each edge.
- Only F requests: go to BUS_F.
- Only D requests: go to BUS_D.
- Both request: go to BUS_F if streak == DATA_BURST_MAX, else BUS_D.
- On entry to BUS_x, the requester's adr/we/dat/sel are latched onto the mem_* outputs (F: we=0, sel=1111), mem_stb_o=1, and grant_o is set. These take effect in the cycle after the sampling edge.

Streak counter (4-bit):
- F grant: cleared.
- D grant with f_req_i high: incremented, saturating at DATA_BURST_MAX.
- D grant with f_req_i low: cleared.

BUS_x (ack path):
- On an edge with mem_ack_i=1: go to DONE; mem_stb_o=0, grant_o=00.
- The owner's ack_o is set to 1 for the DONE cycle only.
- For a read, owner's dat_o captures mem_dat_i from that edge and holds it until the next ack for that port.

BUS_x (timeout path):
- The timeout counter starts at 0 on entering BUS_x and increments each BUS_x cycle.
- When it reaches TIMEOUT with no ack: go to DONE with err_o instead of ack_o; mem_stb_o drops.
- If ack and timeout occur on the same edge, ack wins.

DONE:
- Lasts exactly one cycle, with requests ignored; then go to IDLE.
- The requester must deassert req during the DONE cycle, so there is no spurious regrant.

Timing and invariants:
- Minimum transaction: grant edge, one strobe cycle, ack edge, DONE cycle, giving a 3-cycle request-to-ack latency with a zero-wait slave.
- Never both ack_o, never ack_o and err_o together; mem_stb_o is never high in IDLE or DONE.
- mem_* address, data and control are stable while mem_stb_o=1.
- req inputs changing during BUS_x do not affect the latched transaction.
- A requester dropping req before completion (protocol violation) does not abort the bus cycle; completion is still pulsed.

Test Plan:
1. Reset/idle: hold rst_i low 3 cycles, then release with no reqs -> all outputs 0 and grant_o=00 for 10 cycles.
2. Single fetch, zero-wait slave: f_req_i at adr 0x00001000, slave acks on the first strobe cycle returning 0xDEADBEEF -> mem_adr_o=0x1000, mem_we_o=0, mem_sel_o=1111; f_ack_o pulses 3 cycles after the request, f_dat_o=0xDEADBEEF.
3. Data write with 2 wait states: d_we_i=1, adr 0x20, dat 0x12345678, sel 0011 -> mem_stb_o high exactly 3 cycles with those values; d_ack_o pulses once; f_ack_o stays 0.
4. Contention/anti-starvation: f_req_i and d_req_i held continuously (D re-requests after each ack), DATA_BURST_MAX=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
5. Timeout: TIMEOUT=8, slave never acks on a D read -> mem_stb_o high 8 cycles, then d_err_o pulses once and d_ack_o stays 0. Repeat with ack arriving on cycle 8 -> d_ack_o pulses, no err.
6. Async reset mid-cycle: assert rst_i low in the second strobe cycle of a fetch -> mem_stb_o and grant_o fall without a clock edge, and no f_ack_o or f_err_o after release.

Source files
------------

// File: rtl/muskoka_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muskoka_mem_arbiter
// Purpose  : Shares the single Muskoka memory bus port between the
//            instruction-fetch port (F) and the load/store port (D).
//            Data normally wins contention. A streak counter forces a fetch
//            grant after DATA_BURST_MAX data grants made while fetch waited.
//            Stuck bus cycles are aborted after TIMEOUT strobe cycles.
// Ports    : clk_i, rst_i (async, active-low)
//            f_req_i/f_adr_i         -> f_dat_o/f_ack_o/f_err_o
//            d_req_i/d_we_i/d_adr_i/d_dat_i/d_sel_i
//                                    -> d_dat_o/d_ack_o/d_err_o
//            mem_stb_o/mem_we_o/mem_adr_o/mem_dat_o/mem_sel_o <- mem_dat_i/mem_ack_i
//            grant_o : 00 none, 01 F, 10 D
// Revision : 1.0 - initial release
// ============================================================================
module muskoka_mem_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4,    // 1..15
  parameter int unsigned TIMEOUT        = 255   // 0 disables, 0..1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // fetch port
  input  logic        f_req_i,
  input  logic [31:0] f_adr_i,
  output logic [31:0] f_dat_o,
  output logic        f_ack_o,
  output logic        f_err_o,
  // data port
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  // memory bus
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  // arbitration status
  output logic [1:0]  grant_o
);

  localparam logic [3:0] BURST_LIMIT = 4'(DATA_BURST_MAX);
  // Compared against the pre-increment count, so the abort edge is the one
  // that ends the TIMEOUT-th strobe cycle.
  localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT - 1);
  localparam logic       TMO_EN      = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_F = 2'd1,
    ST_BUS_D = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  streak_q;
  logic [9:0]  tmo_q;
  logic [1:0]  grant_q;
  logic        mem_stb_q;
  logic        mem_we_q;
  logic [31:0] mem_adr_q;
  logic [31:0] mem_dat_q;
  logic [3:0]  mem_sel_q;
  logic [31:0] f_dat_q;
  logic        f_ack_q;
  logic        f_err_q;
  logic [31:0] d_dat_q;
  logic        d_ack_q;
  logic        d_err_q;

  logic        fetch_wins;
  logic        tmo_expire;
  logic [3:0]  streak_inc;

  // Fetch takes the bus when alone, or when data has had its full burst.
  assign fetch_wins = f_req_i && (!d_req_i || (streak_q >= BURST_LIMIT));
  assign tmo_expire = TMO_EN && (tmo_q == TMO_LAST);
  assign streak_inc = (streak_q >= BURST_LIMIT) ? BURST_LIMIT : (streak_q + 4'd1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      tmo_q     <= '0;
      grant_q   <= 2'b00;
      mem_stb_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      mem_sel_q <= '0;
      f_dat_q   <= '0;
      f_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      d_dat_q   <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      f_ack_q <= 1'b0;
      f_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (fetch_wins) begin
            state_q   <= ST_BUS_F;
            grant_q   <= 2'b01;
            mem_stb_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_adr_q <= f_adr_i;
            mem_dat_q <= '0;
            mem_sel_q <= 4'b1111;
            streak_q  <= '0;
          end else if (d_req_i) begin
            state_q   <= ST_BUS_D;
            grant_q   <= 2'b10;
            mem_stb_q <= 1'b1;
            mem_we_q  <= d_we_i;
            mem_adr_q <= d_adr_i;
            mem_dat_q <= d_dat_i;
            mem_sel_q <= d_sel_i;
            // Only data grants that make fetch wait count toward the streak.
            streak_q  <= f_req_i ? streak_inc : 4'd0;
          end
        end

        ST_BUS_F, ST_BUS_D: begin
          if (mem_ack_i) begin
            // Ack beats a timeout landing on the same edge.
            state_q   <= ST_DONE;
            mem_stb_q <= 1'b0;
            grant_q   <= 2'b00;
            if (state_q == ST_BUS_F) begin
              f_ack_q <= 1'b1;
              f_dat_q <= mem_dat_i;
            end else begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_dat_q <= mem_dat_i;
              end
            end
          end else if (tmo_expire) begin
            state_q   <= ST_DONE;
            mem_stb_q <= 1'b0;
            grant_q   <= 2'b00;
            if (state_q == ST_BUS_F) begin
              f_err_q <= 1'b1;
            end else begin
              d_err_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + 10'd1;
          end
        end

        ST_DONE: begin
          // One dead cycle so a requester dropping req now is never regranted.
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign mem_stb_o = mem_stb_q;
  assign mem_we_o  = mem_we_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_dat_o = mem_dat_q;
  assign mem_sel_o = mem_sel_q;
  assign f_dat_o   = f_dat_q;
  assign f_ack_o   = f_ack_q;
  assign f_err_o   = f_err_q;
  assign d_dat_o   = d_dat_q;
  assign d_ack_o   = d_ack_q;
  assign d_err_o   = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_muskoka_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muskoka_mem_arbiter
// Purpose  : Self-checking bench for muskoka_mem_arbiter. A transaction-level
//            model predicts owner, bus contents and completions every cycle;
//            directed tests pin literal values for latency, burst pattern,
//            timeout and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muskoka_mem_arbiter;

  localparam int BURST = 4;
  localparam int TMO   = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        f_req_i = 1'b0;
  logic [31:0] f_adr_i = '0;
  logic [31:0] f_dat_o;
  logic        f_ack_o, f_err_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_adr_i = '0;
  logic [31:0] d_dat_i = '0;
  logic [3:0]  d_sel_i = '0;
  logic [31:0] d_dat_o;
  logic        d_ack_o, d_err_o;
  logic        mem_stb_o, mem_we_o;
  logic [31:0] mem_adr_o, mem_dat_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_dat_i = '0;
  logic        mem_ack_i = 1'b0;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  muskoka_mem_arbiter #(.DATA_BURST_MAX(BURST), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_req_i(f_req_i), .f_adr_i(f_adr_i), .f_dat_o(f_dat_o),
    .f_ack_o(f_ack_o), .f_err_o(f_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_adr_i(d_adr_i), .d_dat_i(d_dat_i),
    .d_sel_i(d_sel_i), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_sel_o(mem_sel_o), .mem_dat_i(mem_dat_i),
    .mem_ack_i(mem_ack_i), .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- slave: acks after slv_wait extra strobe cycles ----------
  int          slv_wait  = 0;
  bit          slv_never = 1'b0;
  logic [31:0] slv_data  = '0;
  int          slv_cnt   = 0;

  always @(posedge clk_i) begin
    #1;
    if (mem_stb_o) begin
      mem_ack_i = !slv_never && (slv_cnt == slv_wait);
      mem_dat_i = slv_data;
      slv_cnt++;
    end else begin
      mem_ack_i = 1'b0;
      slv_cnt   = 0;
    end
  end

  // ---------------- transaction-level reference model -----------------------
  // m_owner: 0 none, 1 F, 2 D.  m_fin: 0 none, 1 ack, 2 err (for m_fin_port).
  int          m_owner = 0, m_fin = 0, m_fin_port = 0, m_streak = 0, m_age = 0;
  logic [31:0] m_adr = '0, m_wdat = '0, m_fdat = '0, m_ddat = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_sel = '0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_owner = 0; m_fin = 0; m_fin_port = 0; m_streak = 0; m_age = 0;
      m_fdat = '0; m_ddat = '0;
    end else if (m_fin != 0) begin
      m_fin = 0;                       // completion cycle: requests not looked at
    end else if (m_owner == 0) begin
      if (f_req_i && (!d_req_i || m_streak == BURST)) begin
        m_owner = 1; m_adr = f_adr_i; m_we = 1'b0; m_sel = 4'hF;
        m_streak = 0; m_age = 0;
      end else if (d_req_i) begin
        m_owner = 2; m_adr = d_adr_i; m_we = d_we_i; m_wdat = d_dat_i; m_sel = d_sel_i;
        m_streak = f_req_i ? ((m_streak < BURST) ? m_streak + 1 : BURST) : 0;
        m_age = 0;
      end
    end else begin
      m_age++;                         // strobe cycles completed so far
      if (mem_ack_i) begin
        if (!m_we) begin
          if (m_owner == 1) m_fdat = mem_dat_i; else m_ddat = mem_dat_i;
        end
        m_fin = 1; m_fin_port = m_owner; m_owner = 0;
      end else if (TMO != 0 && m_age == TMO) begin
        m_fin = 2; m_fin_port = m_owner; m_owner = 0;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ------------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      if (!rst_i) begin
        chk("rst_ctl", 32'({mem_stb_o, mem_we_o, grant_o, f_ack_o, f_err_o,
                            d_ack_o, d_err_o, mem_sel_o}), 32'h0);
        chk("rst_adr", mem_adr_o, 32'h0);
        chk("rst_wdat", mem_dat_o, 32'h0);
        chk("rst_fdat", f_dat_o, 32'h0);
        chk("rst_ddat", d_dat_o, 32'h0);
      end else begin
        chk("grant", 32'(grant_o), 32'(m_owner));
        chk("stb", 32'(mem_stb_o), 32'(m_owner != 0));
        chk("done_flags", 32'({f_ack_o, f_err_o, d_ack_o, d_err_o}),
            32'({m_fin == 1 && m_fin_port == 1, m_fin == 2 && m_fin_port == 1,
                 m_fin == 1 && m_fin_port == 2, m_fin == 2 && m_fin_port == 2}));
        chk("f_dat", f_dat_o, m_fdat);
        chk("d_dat", d_dat_o, m_ddat);
        if (m_owner != 0) begin
          chk("bus_adr", mem_adr_o, m_adr);
          chk("bus_ctl", 32'({mem_we_o, mem_sel_o}), 32'({m_we, m_sel}));
          if (m_we) chk("bus_wdat", mem_dat_o, m_wdat);
        end
      end
    end
  end

  // ---------------- event counters and first-strobe capture -----------------
  int          n_stb = 0, n_fack = 0, n_ferr = 0, n_dack = 0, n_derr = 0;
  bit          prev_stb = 1'b0;
  logic [1:0]  prev_grant = 2'b00;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;
  int          gseq[$];

  always @(negedge clk_i) begin
    if (mem_stb_o) n_stb++;
    if (mem_stb_o && !prev_stb) begin
      cap_adr = mem_adr_o; cap_dat = mem_dat_o; cap_we = mem_we_o; cap_sel = mem_sel_o;
    end
    prev_stb = mem_stb_o;
    if (f_ack_o) n_fack++;
    if (f_err_o) n_ferr++;
    if (d_ack_o) n_dack++;
    if (d_err_o) n_derr++;
    if (grant_o != 2'b00 && prev_grant == 2'b00) gseq.push_back(int'(grant_o));
    prev_grant = grant_o;
  end

  task automatic clear_counts();
    n_stb = 0; n_fack = 0; n_ferr = 0; n_dack = 0; n_derr = 0;
  endtask

  // ---------------- requester tasks (called at posedge+1) -------------------
  // cyc counts cycles from the request cycle through the completion cycle.
  task automatic f_txn(input logic [31:0] adr, output int cyc, output bit was_err);
    int n; bit fin;
    f_adr_i = adr; f_req_i = 1'b1; n = 0; fin = 1'b0; was_err = 1'b0;
    while (!fin && n < 200) begin
      @(posedge clk_i); #1; n++;
      if (f_ack_o || f_err_o) begin fin = 1'b1; was_err = f_err_o; end
    end
    f_req_i = 1'b0;
    cyc = n + 1;
    chk("f_done_in_bound", 32'(fin), 32'h1);
  endtask

  task automatic d_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int cyc, output bit was_err);
    int n; bit fin;
    d_we_i = we; d_adr_i = adr; d_dat_i = dat; d_sel_i = sel; d_req_i = 1'b1;
    n = 0; fin = 1'b0; was_err = 1'b0;
    while (!fin && n < 200) begin
      @(posedge clk_i); #1; n++;
      if (d_ack_o || d_err_o) begin fin = 1'b1; was_err = d_err_o; end
    end
    d_req_i = 1'b0;
    cyc = n + 1;
    chk("d_done_in_bound", 32'(fin), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ------------------------------------------
  initial begin
    int cyc;
    bit e;
    int exp_seq[10];
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

    // 1: reset held 3 cycles, then 10 quiet cycles
    @(posedge clk_i);
    chk_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      chk("t1_idle", 32'({mem_stb_o, grant_o, f_ack_o, f_err_o, d_ack_o, d_err_o}), 32'h0);
    end
    @(posedge clk_i); #1;

    // 2: single fetch, zero-wait slave
    slv_wait = 0; slv_never = 1'b0; slv_data = 32'hDEADBEEF; clear_counts();
    f_txn(32'h0000_1000, cyc, e);
    chk("t2_latency", 32'(cyc), 32'd3);
    chk("t2_err", 32'(e), 32'h0);
    chk("t2_fdat", f_dat_o, 32'hDEADBEEF);
    chk("t2_adr", cap_adr, 32'h0000_1000);
    chk("t2_we_sel", 32'({cap_we, cap_sel}), 32'h0F);
    @(posedge clk_i); #1;
    chk("t2_stb_cycles", 32'(n_stb), 32'd1);
    chk("t2_fack_count", 32'(n_fack), 32'd1);

    // 3: data write, two wait states
    slv_wait = 2; slv_data = 32'h0BAD_0BAD; clear_counts();
    d_txn(1'b1, 32'h20, 32'h12345678, 4'b0011, cyc, e);
    @(posedge clk_i); #1;
    chk("t3_stb_cycles", 32'(n_stb), 32'd3);
    chk("t3_adr", cap_adr, 32'h20);
    chk("t3_wdat", cap_dat, 32'h12345678);
    chk("t3_we_sel", 32'({cap_we, cap_sel}), 32'h13);
    chk("t3_dack_count", 32'(n_dack), 32'd1);
    chk("t3_fack_count", 32'(n_fack), 32'd0);
    chk("t3_ddat_untouched", d_dat_o, 32'h0);

    // 4: contention, fetch waits behind a data burst
    slv_wait = 0; slv_data = 32'h0000_5A5A;
    gseq.delete();
    fork
      begin
        int c4; bit e4;
        for (int i = 0; i < 2; i++) begin
          f_txn(32'h0000_2000 + 32'(4 * i), c4, e4);
          @(posedge clk_i); #1;
        end
      end
      begin
        int c4; bit e4;
        for (int j = 0; j < 8; j++) begin
          d_txn(j[0], 32'h100 + 32'(4 * j), 32'h1111_0000 + 32'(j), 4'b1111, c4, e4);
          @(posedge clk_i); #1;
        end
      end
    join
    chk("t4_ngrants", 32'(gseq.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_grant%0d", k), 32'(gseq[k]), 32'(exp_seq[k]));
    end

    // 5a: slave never answers a data read
    slv_never = 1'b1; clear_counts();
    d_txn(1'b0, 32'h40, 32'h0, 4'hF, cyc, e);
    @(posedge clk_i); #1;
    chk("t5a_err", 32'(e), 32'h1);
    chk("t5a_stb_cycles", 32'(n_stb), 32'd8);
    chk("t5a_derr_count", 32'(n_derr), 32'd1);
    chk("t5a_dack_count", 32'(n_dack), 32'd0);

    // 5b: ack arrives in the same cycle the timeout would fire
    slv_never = 1'b0; slv_wait = 7; slv_data = 32'hCAFEF00D; clear_counts();
    d_txn(1'b0, 32'h44, 32'h0, 4'hF, cyc, e);
    @(posedge clk_i); #1;
    chk("t5b_err", 32'(e), 32'h0);
    chk("t5b_stb_cycles", 32'(n_stb), 32'd8);
    chk("t5b_dack_count", 32'(n_dack), 32'd1);
    chk("t5b_derr_count", 32'(n_derr), 32'd0);
    chk("t5b_ddat", d_dat_o, 32'hCAFEF00D);

    // 6: asynchronous reset during the second strobe cycle of a fetch
    slv_never = 1'b1;
    f_adr_i = 32'h0000_3000; f_req_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("t6_stb_before", 32'({mem_stb_o, grant_o}), 32'h5);
    #1 rst_i = 1'b0;
    #1;
    chk("t6_async_drop", 32'({mem_stb_o, grant_o}), 32'h0);
    f_req_i = 1'b0; slv_never = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    clear_counts();
    repeat (10) @(posedge clk_i);
    #1;
    chk("t6_no_completion", 32'(n_fack + n_ferr), 32'd0);
    chk("t6_no_strobe", 32'(n_stb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
